// File: rtl/updown_button_counter.sv
// updown_button_counter: two-button up/down event counter with a 16-bit count.
// Each press of u increments and each press of d decrements c_out once,
// however long the button is held. Decrement saturates at zero.
// Build option: define TOP_SYSTEM_SAT_MAX_EN to saturate increment at 0xFFFF;
// otherwise increment at 0xFFFF wraps to 0x0000.
module updown_button_counter (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 u,
  input  logic                 d,
  output logic [15:0]          c_out
);

  localparam int unsigned CountW = 16;
  localparam logic [CountW-1:0] CountMax  = '1;
  localparam logic [CountW-1:0] CountZero = '0;
  localparam logic [CountW-1:0] CountOne  = CountW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2,
    HOLD = 2'd3
  } state_t;

  logic   u_meta;
  logic   u_s;
  logic   d_meta;
  logic   d_s;
  state_t state;
  logic [CountW-1:0] count_up_c;
  logic [CountW-1:0] count_down_c;

  // Two-flop synchronizers for the asynchronous button levels
  always_ff @(posedge clk) begin
    if (reset) begin
      u_meta <= 1'b0;
      u_s    <= 1'b0;
      d_meta <= 1'b0;
      d_s    <= 1'b0;
    end else begin
      u_meta <= u;
      u_s    <= u_meta;
      d_meta <= d;
      d_s    <= d_meta;
    end
  end

  // Next count values for an up or down event
  always_comb begin
    count_up_c   = c_out + CountOne;
    count_down_c = c_out;
`ifdef TOP_SYSTEM_SAT_MAX_EN
    if (c_out == CountMax) begin
      count_up_c = CountMax;
    end
`else
    if (c_out == CountMax) begin
      count_up_c = CountZero;
    end
`endif
    if (c_out != CountZero) begin
      count_down_c = c_out - CountOne;
    end
  end

  // Press FSM; count changes on the edge that registers INC or DEC
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      c_out <= CountZero;
    end else begin
      case (state)
        IDLE: begin
          if (u_s && !d_s) begin
            state <= INC;
            c_out <= count_up_c;
          end else if (!u_s && d_s) begin
            state <= DEC;
            c_out <= count_down_c;
          end else if (u_s && d_s) begin
            // simultaneous press is ignored until both are released
            state <= HOLD;
          end
        end
        INC, DEC: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!u_s && !d_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_button_counter.sv
// Directed self-checking bench for updown_button_counter.
module tb_updown_button_counter;

  logic        clk;
  logic        reset;
  logic        u;
  logic        d;
  logic [15:0] c_out;

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic        rst;
    logic        up;
    logic        dn;
    int          cycles;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  updown_button_counter dut (
    .clk   (clk),
    .reset (reset),
    .u     (u),
    .d     (d),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] exp);
    n_tests++;
    if (c_out !== exp) begin
      n_fail++;
      $display("FAIL %s: c_out=0x%04h expected=0x%04h", name, c_out, exp);
    end
  endtask

  // Drive inputs just after a falling edge, run n rising edges, end at a falling edge
  task automatic apply(input logic rst, input logic up, input logic dn, input int n);
    reset = rst;
    u     = up;
    d     = dn;
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic rst, input logic up, input logic dn,
                              input int cycles, input logic [15:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.up = up; v.dn = dn; v.cycles = cycles; v.exp = exp; v.name = name;
    return v;
  endfunction

  logic [15:0] base;
  logic [15:0] wrap_exp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    u = 1'b0;
    d = 1'b0;
`ifdef TOP_SYSTEM_SAT_MAX_EN
    wrap_exp = 16'hFFFF;
`else
    wrap_exp = 16'h0000;
`endif

    vecs.push_back(mk(1, 0, 0,  2, 16'd0, "reset"));
    vecs.push_back(mk(0, 1, 0,  3, 16'd1, "up1_press"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd1, "up1_release"));
    vecs.push_back(mk(0, 1, 0,  3, 16'd2, "up2_press"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd2, "up2_release"));
    vecs.push_back(mk(0, 0, 1,  3, 16'd1, "down_press"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd1, "down_release"));
    vecs.push_back(mk(1, 0, 0,  2, 16'd0, "reset2"));
    vecs.push_back(mk(0, 0, 1,  3, 16'd0, "down_at_zero"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd0, "down_at_zero_rel"));
    vecs.push_back(mk(0, 1, 1,  3, 16'd0, "both_press"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd0, "both_release"));
    vecs.push_back(mk(0, 1, 0,  3, 16'd1, "up_after_both"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd1, "up_after_both_rel"));
    vecs.push_back(mk(0, 1, 0, 20, 16'd2, "long_hold_up"));
    vecs.push_back(mk(0, 1, 1,  5, 16'd2, "down_while_up_held"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd2, "release_both"));
    vecs.push_back(mk(0, 0, 1,  3, 16'd1, "down_after_hold"));
    vecs.push_back(mk(0, 0, 0,  5, 16'd1, "down_after_hold_rel"));

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].up, vecs[i].dn, vecs[i].cycles);
      check(vecs[i].name, vecs[i].exp);
    end

    // Latency: value unchanged after edges k and k+1, updated after k+2
    base = c_out;
    apply(0, 1, 0, 1);
    check("lat_edge_k", base);
    apply(0, 1, 0, 1);
    check("lat_edge_k1", base);
    apply(0, 1, 0, 1);
    check("lat_edge_k2", base + 16'd1);
    apply(0, 0, 0, 6);
    check("lat_release", base + 16'd1);

    // Preload the top of range and press up
    force dut.c_out = 16'hFFFF;
    #1;
    release dut.c_out;
    apply(0, 0, 0, 1);
    check("preload", 16'hFFFF);
    apply(0, 1, 0, 3);
    check("up_at_max", wrap_exp);
    apply(0, 0, 0, 5);
    check("up_at_max_rel", wrap_exp);

    // Reset mid-press aborts the press without a spurious count
    apply(1, 0, 0, 2);
    apply(0, 1, 0, 3);
    apply(0, 0, 0, 5);
    check("pre_abort", 16'd1);
    apply(0, 1, 0, 2);
    apply(1, 0, 0, 2);
    check("reset_mid_press", 16'd0);
    apply(0, 0, 0, 6);
    check("after_abort", 16'd0);

    // Button held through reset counts as a new press afterwards
    apply(1, 1, 0, 2);
    check("held_in_reset", 16'd0);
    apply(0, 1, 0, 2);
    check("held_after_reset_k1", 16'd0);
    apply(0, 1, 0, 1);
    check("held_after_reset_k2", 16'd1);
    apply(0, 0, 0, 6);
    check("held_after_reset_rel", 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
